// File: rtl/ace_core_pkg.sv
// Shared defaults and helpers for the ace core front-end blocks.
package ace_core_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_DEPTH  = 32;
   localparam int DEFAULT_IN_W   = 8;
   localparam int DEFAULT_OUT_W  = 4;

   // Width of a bundle holding `lanes` words of `data_w` bits each.
   function automatic int lane_bits(input int lanes, input int data_w);
      return lanes * data_w;
   endfunction

endpackage

// File: rtl/inst_compact.sv
// Squeezes the valid lanes of a write bundle down to lane 0 upward and counts them.
module inst_compact
   import ace_core_pkg::*;
#(
   parameter  int DATA_W = DEFAULT_DATA_W,
   parameter  int IN_W   = DEFAULT_IN_W,
   localparam int CNT_W  = $clog2(IN_W + 1)
) (
   input  logic [lane_bits(IN_W, DATA_W)-1:0] in_inst_i,
   input  logic [IN_W-1:0]                    in_vld_i,
   output logic [lane_bits(IN_W, DATA_W)-1:0] packed_o,
   output logic [CNT_W-1:0]                   cnt_o
);

   logic [CNT_W-1:0] idx;

   // NOTE: idx is a running slot counter inside one evaluation, so it is
   // updated with blocking assignments and given a default before the loop.
   always_comb begin
      packed_o = '0;
      idx      = '0;
      for (int k = 0; k < IN_W; k++) begin
         if (in_vld_i[k]) begin
            packed_o[idx*DATA_W +: DATA_W] = in_inst_i[k*DATA_W +: DATA_W];
            idx = idx + CNT_W'(1);
         end
      end
      cnt_o = idx;
   end

endmodule

// File: rtl/inst_queue.sv
// Multi-lane instruction queue: compacted bundle writes, up to OUT_W in-order
// reads per cycle, synchronous flush.
module inst_queue
   import ace_core_pkg::*;
#(
   parameter  int DATA_W = DEFAULT_DATA_W,
   parameter  int DEPTH  = DEFAULT_DEPTH,
   parameter  int IN_W   = DEFAULT_IN_W,
   parameter  int OUT_W  = DEFAULT_OUT_W,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int TAKE_W = $clog2(OUT_W + 1),
   localparam int WN_W   = $clog2(IN_W + 1)
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                flush_i,
   input  logic [lane_bits(IN_W, DATA_W)-1:0]  in_inst_i,
   input  logic [IN_W-1:0]                     in_vld_i,
   output logic                                in_ready_o,
   output logic [lane_bits(OUT_W, DATA_W)-1:0] out_inst_o,
   output logic [OUT_W-1:0]                    out_vld_o,
   input  logic [TAKE_W-1:0]                   out_take_i,
   output logic [CNT_W-1:0]                    count_o,
   output logic                                full_o,
   output logic                                empty_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [lane_bits(IN_W, DATA_W)-1:0] packed_inst;
   logic [WN_W-1:0]   wr_n;
   logic              wr_en;
   logic [CNT_W-1:0]  avail, take_ext, rd_n, wr_cnt, rd_cnt;
   logic [PTR_W-1:0]  wr_idx, rd_idx;

   inst_compact #(
      .DATA_W (DATA_W),
      .IN_W   (IN_W)
   ) u_compact (
      .in_inst_i (in_inst_i),
      .in_vld_i  (in_vld_i),
      .packed_o  (packed_inst),
      .cnt_o     (wr_n)
   );

   // Acceptance looks only at the registered count; a read in the same cycle
   // does not free space early, which keeps in_ready_o off the take path.
   assign in_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(IN_W);
   assign full_o     = !in_ready_o;
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign wr_en      = in_ready_o && (|in_vld_i) && !flush_i;

   always_comb begin
      avail    = (count_q > CNT_W'(OUT_W)) ? CNT_W'(OUT_W) : count_q;
      take_ext = CNT_W'(out_take_i);
      rd_n     = (take_ext < avail) ? take_ext : avail;
      wr_cnt   = wr_en ? CNT_W'(wr_n) : '0;
      rd_cnt   = flush_i ? '0 : rd_n;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt);
         rd_ptr_d = rd_ptr_q + PTR_W'(rd_cnt);
         count_d  = count_q + wr_cnt - rd_cnt;
      end
   end

   // Pointer arithmetic in PTR_W bits wraps naturally, splitting a bundle
   // across the end and start of the array.
   always_comb begin
      mem_d  = mem_q;
      wr_idx = '0;
      if (wr_en) begin
         for (int j = 0; j < IN_W; j++) begin
            wr_idx = wr_ptr_q + PTR_W'(j);
            if (WN_W'(j) < wr_n) begin
               mem_d[wr_idx] = packed_inst[j*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_comb begin
      out_vld_o  = '0;
      out_inst_o = '0;
      rd_idx     = '0;
      for (int k = 0; k < OUT_W; k++) begin
         rd_idx       = rd_ptr_q + PTR_W'(k);
         out_vld_o[k] = CNT_W'(k) < count_q;
         if (out_vld_o[k]) begin
            out_inst_o[k*DATA_W +: DATA_W] = mem_q[rd_idx];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage has no reset; count_q gates every read, so stale words are
   // never visible and the array can map onto plain flops or RAM.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a word queue models the FIFO contents.
module tb_inst_queue;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int IN_W   = 8;
   localparam int OUT_W  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int TAKE_W = $clog2(OUT_W + 1);

   logic                      clock = 1'b0;
   logic                      reset_n;
   logic                      flush_i;
   logic [IN_W*DATA_W-1:0]    in_inst_i;
   logic [IN_W-1:0]           in_vld_i;
   logic                      in_ready_o;
   logic [OUT_W*DATA_W-1:0]   out_inst_o;
   logic [OUT_W-1:0]          out_vld_o;
   logic [TAKE_W-1:0]         out_take_i;
   logic [CNT_W-1:0]          count_o;
   logic                      full_o;
   logic                      empty_o;

   logic [DATA_W-1:0] sbq[$];
   int vectors     = 0;
   int miscompares = 0;

   inst_queue #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IN_W   (IN_W),
      .OUT_W  (OUT_W)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .flush_i    (flush_i),
      .in_inst_i  (in_inst_i),
      .in_vld_i   (in_vld_i),
      .in_ready_o (in_ready_o),
      .out_inst_o (out_inst_o),
      .out_vld_o  (out_vld_o),
      .out_take_i (out_take_i),
      .count_o    (count_o),
      .full_o     (full_o),
      .empty_o    (empty_o)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [IN_W*DATA_W-1:0] bundle(input logic [31:0] base);
      logic [IN_W*DATA_W-1:0] r;
      for (int k = 0; k < IN_W; k++) r[k*DATA_W +: DATA_W] = base + 32'(k);
      return r;
   endfunction

   function automatic logic [OUT_W*DATA_W-1:0] exp_inst();
      logic [OUT_W*DATA_W-1:0] r = '0;
      for (int k = 0; k < OUT_W; k++)
         if (k < sbq.size()) r[k*DATA_W +: DATA_W] = sbq[k];
      return r;
   endfunction

   function automatic logic [OUT_W-1:0] exp_vld();
      logic [OUT_W-1:0] r = '0;
      for (int k = 0; k < OUT_W; k++) r[k] = (k < sbq.size());
      return r;
   endfunction

   function automatic logic exp_ready();
      return (DEPTH - sbq.size()) >= IN_W;
   endfunction

   // One clock with the given stimulus; the scoreboard pops what is taken
   // and pushes the valid lanes in ascending order when the write is accepted.
   task automatic step(input logic [IN_W-1:0] vld, input logic [31:0] base,
                       input int take, input logic flush);
      bit ready;
      int n;
      in_inst_i  = bundle(base);
      in_vld_i   = vld;
      out_take_i = TAKE_W'(take);
      flush_i    = flush;
      ready = exp_ready();
      n = take;
      if (n > sbq.size()) n = sbq.size();
      if (n > OUT_W) n = OUT_W;
      @(posedge clock);
      #1;
      if (flush) begin
         sbq.delete();
      end else begin
         repeat (n) void'(sbq.pop_front());
         if (ready && vld != '0)
            for (int k = 0; k < IN_W; k++)
               if (vld[k]) sbq.push_back(base + 32'(k));
      end
      in_vld_i   = '0;
      out_take_i = '0;
      flush_i    = 1'b0;
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      flush_i    = 1'b0;
      in_inst_i  = '0;
      in_vld_i   = '0;
      out_take_i = '0;
      #12;
      vectors++;
      if (count_o !== '0 || out_vld_o !== '0 || out_inst_o !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: count=%0d vld=%h inst=%h, expected 0/0/0", count_o, out_vld_o, out_inst_o);
      end
      vectors++;
      if ({in_ready_o, full_o, empty_o} !== 3'b101) begin
         miscompares++;
         $display("FAIL reset_flags: ready/full/empty=%b expected 101", {in_ready_o, full_o, empty_o});
      end
      reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_full_bundle();
      step(8'hFF, 32'd0, 0, 1'b0);
      vectors++;
      if (count_o !== CNT_W'(8) || out_vld_o !== 4'hF) begin
         miscompares++;
         $display("FAIL full_bundle_count: count=%0d vld=%h expected 8/f", count_o, out_vld_o);
      end
      vectors++;
      if (out_inst_o !== {32'd3, 32'd2, 32'd1, 32'd0} || out_inst_o !== exp_inst()) begin
         miscompares++;
         $display("FAIL full_bundle_lanes: got %h expected %h", out_inst_o, {32'd3, 32'd2, 32'd1, 32'd0});
      end
   endtask

   task automatic test_holes();
      step('0, 32'd0, 0, 1'b1);
      step(8'b1010_0101, 32'hA0, 0, 1'b0);
      vectors++;
      if (count_o !== CNT_W'(4) || out_vld_o !== 4'hF) begin
         miscompares++;
         $display("FAIL holes_count: count=%0d vld=%h expected 4/f", count_o, out_vld_o);
      end
      vectors++;
      if (out_inst_o !== {32'hA7, 32'hA5, 32'hA2, 32'hA0}) begin
         miscompares++;
         $display("FAIL holes_lanes: got %h expected a7/a5/a2/a0", out_inst_o);
      end
   endtask

   task automatic test_full();
      step('0, 32'd0, 0, 1'b1);
      for (int i = 0; i < 3; i++) step(8'hFF, 32'h100 + 32'(i * 8), 0, 1'b0);
      vectors++;
      if (count_o !== CNT_W'(24) || in_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL full_at_24: count=%0d ready=%b expected 24/1", count_o, in_ready_o);
      end
      step(8'h01, 32'h200, 0, 1'b0);
      vectors++;
      if (count_o !== CNT_W'(25) || in_ready_o !== 1'b0 || full_o !== 1'b1) begin
         miscompares++;
         $display("FAIL full_at_25: count=%0d ready=%b full=%b expected 25/0/1", count_o, in_ready_o, full_o);
      end
      step(8'hFF, 32'h300, 0, 1'b0);
      vectors++;
      if (count_o !== CNT_W'(25) || count_o !== CNT_W'(sbq.size())) begin
         miscompares++;
         $display("FAIL full_reject: count=%0d expected 25", count_o);
      end
      step('0, 32'd0, 4, 1'b0);
      vectors++;
      if (count_o !== CNT_W'(21) || in_ready_o !== 1'b1 || full_o !== 1'b0) begin
         miscompares++;
         $display("FAIL full_drain: count=%0d ready=%b full=%b expected 21/1/0", count_o, in_ready_o, full_o);
      end
      vectors++;
      if (out_inst_o !== exp_inst()) begin
         miscompares++;
         $display("FAIL full_drain_lanes: got %h expected %h", out_inst_o, exp_inst());
      end
   endtask

   task automatic test_wrap();
      step('0, 32'd0, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(8'hFF, 32'h400 + 32'(i * 8), 0, 1'b0);
         step('0, 32'd0, 4, 1'b0);
         step('0, 32'd0, 4, 1'b0);
      end
      step(8'h0F, 32'h500, 0, 1'b0);
      step('0, 32'd0, 4, 1'b0);
      step(8'hFF, 32'hB0, 0, 1'b0);
      vectors++;
      if (count_o !== CNT_W'(8) || out_inst_o !== {32'hB3, 32'hB2, 32'hB1, 32'hB0}) begin
         miscompares++;
         $display("FAIL wrap_first: count=%0d lanes=%h expected 8 b3..b0", count_o, out_inst_o);
      end
      step('0, 32'd0, 4, 1'b0);
      vectors++;
      if (count_o !== CNT_W'(4) || out_inst_o !== {32'hB7, 32'hB6, 32'hB5, 32'hB4}) begin
         miscompares++;
         $display("FAIL wrap_second: count=%0d lanes=%h expected 4 b7..b4", count_o, out_inst_o);
      end
      step('0, 32'd0, 4, 1'b0);
      vectors++;
      if (count_o !== '0 || empty_o !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_drain: count=%0d empty=%b expected 0/1", count_o, empty_o);
      end
   endtask

   task automatic test_underflow();
      step(8'h03, 32'hC0, 0, 1'b0);
      vectors++;
      if (count_o !== CNT_W'(2) || out_vld_o !== 4'h3) begin
         miscompares++;
         $display("FAIL underflow_setup: count=%0d vld=%h expected 2/3", count_o, out_vld_o);
      end
      step('0, 32'd0, 4, 1'b0);
      vectors++;
      if (count_o !== '0 || empty_o !== 1'b1 || out_vld_o !== '0) begin
         miscompares++;
         $display("FAIL underflow_clamp: count=%0d empty=%b vld=%h expected 0/1/0", count_o, empty_o, out_vld_o);
      end
   endtask

   task automatic test_flush();
      step(8'hFF, 32'hD0, 0, 1'b0);
      step(8'h0F, 32'hD8, 0, 1'b0);
      in_inst_i  = bundle(32'hE0);
      in_vld_i   = 8'hFF;
      out_take_i = TAKE_W'(3);
      flush_i    = 1'b1;
      #1;
      vectors++;
      if (count_o !== CNT_W'(12) || out_inst_o !== {32'hD3, 32'hD2, 32'hD1, 32'hD0}) begin
         miscompares++;
         $display("FAIL flush_cycle_outputs: count=%0d lanes=%h expected 12 d3..d0", count_o, out_inst_o);
      end
      step(8'hFF, 32'hE0, 3, 1'b1);
      vectors++;
      if (count_o !== '0 || empty_o !== 1'b1 || out_vld_o !== '0 || out_inst_o !== '0) begin
         miscompares++;
         $display("FAIL flush_result: count=%0d empty=%b vld=%h inst=%h expected 0/1/0/0", count_o, empty_o, out_vld_o, out_inst_o);
      end
   endtask

   task automatic test_reset_mid();
      step(8'hFF, 32'hF0, 0, 1'b0);
      step(8'hFF, 32'hF8, 1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      sbq.delete();
      vectors++;
      if (count_o !== '0 || out_vld_o !== '0 || out_inst_o !== '0 || {in_ready_o, full_o, empty_o} !== 3'b101) begin
         miscompares++;
         $display("FAIL reset_mid: count=%0d vld=%h inst=%h flags=%b expected 0/0/0/101", count_o, out_vld_o, out_inst_o, {in_ready_o, full_o, empty_o});
      end
      reset_n = 1'b1;
      step(8'h81, 32'h60, 0, 1'b0);
      vectors++;
      if (count_o !== CNT_W'(2) || out_inst_o !== {32'h0, 32'h0, 32'h67, 32'h60}) begin
         miscompares++;
         $display("FAIL reset_mid_recover: count=%0d lanes=%h expected 2 67/60", count_o, out_inst_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] base = 32'h1000;
      for (int i = 0; i < 300; i++) begin
         step(8'($urandom_range(0, 255)), base, $urandom_range(0, 7), ($urandom_range(0, 39) == 0));
         base += 32'd8;
         vectors++;
         if (count_o !== CNT_W'(sbq.size())) begin
            miscompares++;
            $display("FAIL b2b_count[%0d]: got %0d expected %0d", i, count_o, sbq.size());
         end
         vectors++;
         if (out_vld_o !== exp_vld() || out_inst_o !== exp_inst()) begin
            miscompares++;
            $display("FAIL b2b_lanes[%0d]: vld=%h inst=%h expected %h/%h", i, out_vld_o, out_inst_o, exp_vld(), exp_inst());
         end
         vectors++;
         if (in_ready_o !== exp_ready() || full_o !== !exp_ready() || empty_o !== (sbq.size() == 0)) begin
            miscompares++;
            $display("FAIL b2b_flags[%0d]: ready=%b full=%b empty=%b size=%0d", i, in_ready_o, full_o, empty_o, sbq.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_bundle();
      test_holes();
      test_full();
      test_wrap();
      test_underflow();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 32, entry count; SHALL be a power of two, at least 2*IN_W.
REQ-003 Parameter IN_W, default 8, write lanes per cycle.
REQ-004 Parameter OUT_W, default 4, read lanes per cycle; SHALL be at most IN_W.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 flush_i  input  1  discard all contents; synchronous.
REQ-008 in_inst_i  input  IN_W*DATA_W  write bundle; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-009 in_vld_i  input  IN_W  per-lane valid; any mask, holes allowed.
REQ-010 in_ready_o  output  1  queue can accept a full bundle this cycle.
REQ-011 out_inst_o  output  OUT_W*DATA_W  oldest OUT_W entries, lane 0 oldest.
REQ-012 out_vld_o  output  OUT_W  thermometer valid, lanes 0..n-1 set.
REQ-013 out_take_i  input  clog2(OUT_W+1)  number of lanes the backend consumes this cycle.
REQ-014 count_o  output  clog2(DEPTH+1)  current occupancy.
REQ-015 full_o / empty_o  output  1 each  full_o = !in_ready_o; empty_o = (count_o == 0).

Function
REQ-016 The queue SHALL set in_ready_o = (DEPTH - count_o >= IN_W), computed from the registered count only; same-cycle reads SHALL NOT be credited.
REQ-017 A write SHALL occur when in_ready_o && |in_vld_i && !flush_i; otherwise the bundle is ignored and no state changes.
REQ-018 On a write, the valid lanes SHALL be compacted in ascending lane order into consecutive entries starting at wr_ptr; wr_n = popcount(in_vld_i).
REQ-019 Invalid lanes SHALL NOT occupy entries and SHALL NOT advance wr_ptr.
REQ-020 The queue SHALL set out_vld_o[k] = (k < count_o).
REQ-021 out_inst_o lane k SHALL equal entry (rd_ptr+k) mod DEPTH when valid, and zero when not valid.
REQ-022 The read path SHALL be combinational from storage; a written entry SHALL be visible on the outputs in the cycle after the write edge.
REQ-023 rd_n = min(out_take_i, popcount(out_vld_o)); a take larger than the available count SHALL be clamped, never underflow.
REQ-024 Next count = count + wr_n - rd_n; simultaneous read and write in one cycle SHALL be supported.
REQ-025 wr_ptr and rd_ptr SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; a bundle straddling the wrap SHALL split across the end and start of the array.
REQ-026 Flush SHALL take priority over read and write: next cycle rd_ptr = wr_ptr = 0, count = 0, and in that cycle the write is discarded and out_take_i is ignored.
REQ-027 During the flush cycle, outputs SHALL still reflect the pre-flush contents.
REQ-028 count_o SHALL never exceed DEPTH.

Reset
REQ-029 While reset_n = 0: rd_ptr = wr_ptr = count_o = 0, out_vld_o = 0, out_inst_o = 0, in_ready_o = 1, full_o = 0, empty_o = 1.
REQ-030 Storage array SHALL NOT be reset.
REQ-031 Assertion of reset mid-operation SHALL discard all contents immediately.

Structure
REQ-032 Default parameter values and the lane-slice width helper SHALL live in shared package ace_core_pkg.
REQ-033 Lane compaction and popcount SHALL be a sub-module inst_compact (inputs: bundle and mask; outputs: packed lanes and count), instantiated once.
REQ-034 The remainder (pointers, count, storage, read mux) SHALL be implemented in inst_queue.

Verification
REQ-035 Reset, then write in_vld_i=8'hFF with words 0..7 -> next cycle count_o=8, out_vld_o=4'hF, lanes show 0,1,2,3.
REQ-036 Write in_vld_i=8'b1010_0101 with words A0..A7 into an empty queue -> count_o=4, lanes show A0,A2,A5,A7.
REQ-037 Fill to count_o=25 -> in_ready_o=0, full_o=1, and a presented bundle is not written; take 4 (count 21) -> next cycle in_ready_o=1.
REQ-038 With rd_ptr=wr_ptr=28, write 8 valid words -> entries 28..31 and 0..3 are filled; a read of 4 then 4 returns all 8 in order.
REQ-039 Count=2 with out_take_i=4 -> rd_n=2, count_o=0, empty_o=1, no underflow.
REQ-040 Count=12 with a simultaneous write of 8, take of 3 and flush_i=1 -> next cycle count_o=0, empty_o=1, out_vld_o=0.
